// File: rtl/egd_arbiter.sv
// egd_arbiter: round-robin sharer of one Exp-Golomb decoder between two requesters; EGD_PERF_CNT_EN builds the grant counters
module egd_arbiter #(
   parameter int DEC_LAT = 2,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic [1:0]        req_valid,
   input  logic [1:0][1:0]   req_sel,
   input  logic [1:0][15:0]  req_bits,
   output logic [1:0]        req_ready,
   output logic [1:0]        rsp_valid,
   output logic [7:0]        rsp_data,
   input  logic [1:0]        rsp_ready,
   output logic [1:0]        dec_sel,
   output logic [15:0]       dec_bits,
   input  logic [7:0]        dec_out,
   output logic              busy,
   output logic [CNT_W-1:0]  grant_cnt0,
   output logic [CNT_W-1:0]  grant_cnt1
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, nxt;
   logic [3:0] cnt;
   logic gnt, last_grant, win, hs;
   always_comb begin
      win = &req_valid ? ~last_grant : req_valid[1];
      req_ready = (reset_n && state == IDLE && !flush && |req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
      hs = |req_ready;
      nxt = state;
      case (state)
         IDLE:    nxt = hs ? WAIT : IDLE;
         WAIT:    nxt = flush ? IDLE : (cnt == 4'd1 ? RESP : WAIT);
         RESP:    nxt = (flush || rsp_ready[gnt]) ? IDLE : RESP;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= nxt;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dec_sel    <= '0;
         dec_bits   <= '0;
         rsp_data   <= '0;
         rsp_valid  <= '0;
         gnt        <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         busy       <= 1'b0;
      end else begin
         busy <= nxt != IDLE;
         if (hs) begin
            dec_sel    <= req_sel[win];
            dec_bits   <= req_bits[win];
            gnt        <= win;
            last_grant <= win;
            cnt        <= 4'(DEC_LAT);
         end else if (state == WAIT) cnt <= cnt - 4'd1;
         // decoder inputs have now been stable for DEC_LAT cycles
         if (state == WAIT && !flush && cnt == 4'd1) begin
            rsp_data  <= dec_out;
            rsp_valid <= gnt ? 2'b10 : 2'b01;
         end else if (nxt == IDLE) rsp_valid <= 2'b00;
      end
   end
`ifdef EGD_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (hs) begin
         if (win) grant_cnt1 <= grant_cnt1 + 1'b1;
         else grant_cnt0 <= grant_cnt0 + 1'b1;
      end
   end
`else
   assign grant_cnt0 = '0;
   assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_egd_arbiter.sv
// tb_egd_arbiter: vector table plus hand sequences against a response scoreboard for egd_arbiter
module tb_egd_arbiter;
   localparam int LAT = 2;
   localparam int CW  = 4;
   logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0;
   logic [1:0] req_valid = '0, rsp_ready = '0;
   logic [1:0][1:0] req_sel = '0;
   logic [1:0][15:0] req_bits = '0;
   logic [1:0] req_ready, rsp_valid, dec_sel;
   logic [7:0] rsp_data, dec_out;
   logic [15:0] dec_bits;
   logic busy;
   logic [CW-1:0] grant_cnt0, grant_cnt1;

   egd_arbiter #(.DEC_LAT(LAT), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .req_valid(req_valid),
      .req_sel(req_sel), .req_bits(req_bits), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
      .dec_sel(dec_sel), .dec_bits(dec_bits), .dec_out(dec_out), .busy(busy),
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1));

   always #5 clk = ~clk;

   // stand-in decoder: ue(v) of the window, modified by the select
   function automatic logic [7:0] dec_model(input logic [1:0] s, input logic [15:0] b);
      int lz;
      bit f;
      logic [7:0] v;
      lz = 8;
      f = 0;
      for (int k = 0; k < 8; k++) if (!f && b[15-k]) begin lz = k; f = 1; end
      if (lz == 8) v = 8'hFF;
      else v = 8'(((1 << lz) - 1) + ((int'(b) >> (15 - 2*lz)) & ((1 << lz) - 1)));
      return s == 2'b10 ? v ^ 8'h80 : s == 2'b11 ? ~v : v;
   endfunction
   assign dec_out = dec_model(dec_sel, dec_bits);

   function automatic logic [CW-1:0] cexp(input int n);
`ifdef EGD_PERF_CNT_EN
      return CW'(n);
`else
      return '0;
`endif
   endfunction

   int n_cmp = 0, n_bad = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {logic [1:0] who; logic [7:0] data;} rsp_t;
   rsp_t sb[$];
   rsp_t r;
   int cyc = 0, acc_cyc = -100;
   int exp_cnt[2] = '{0, 0};
   logic exp_last = 1'b1, w;
   logic [1:0] prev_rv = '0;
   bit chk_gap = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // reference arbiter and scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      if (!reset_n) begin
         sb.delete();
         exp_last = 1'b1;
         exp_cnt = '{0, 0};
         prev_rv = '0;
      end else begin
         chk("ready_not_11", {31'd0, req_ready == 2'b11}, 0);
         chk("ready_while_busy", {31'd0, busy && req_ready != 2'b00}, 0);
         if (req_ready != 2'b00) begin
            w = &req_valid ? ~exp_last : req_valid[1];
            chk("grant", {30'd0, req_ready}, w ? 2 : 1);
            sb.push_back('{w ? 2'b10 : 2'b01, dec_model(req_sel[w], req_bits[w])});
            exp_last = w;
            exp_cnt[w]++;
            if (chk_gap) chk("gap", cyc + 1 - acc_cyc, LAT + 2);
            acc_cyc = cyc + 1;
         end
         if (rsp_valid != 2'b00 && prev_rv == 2'b00) chk("rsp_lat", cyc - acc_cyc, LAT);
         if (flush && busy && sb.size() != 0) void'(sb.pop_front());
         else if ((rsp_valid & rsp_ready) != 2'b00 && !flush) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               r = sb.pop_front();
               chk("rsp_who", {30'd0, rsp_valid}, {30'd0, r.who});
               chk("rsp_data", {24'd0, rsp_data}, {24'd0, r.data});
            end
         end
         prev_rv = rsp_valid;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(input string nm, output logic [1:0] got);
      bit ok;
      ok = 0;
      got = '0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin ok = 1; got = req_ready; end
      end
      if (!ok) chk({nm, "_timeout"}, 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) ok = 1;
      end
      if (!ok) chk({nm, "_drain_timeout"}, 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req_valid = '0;
      flush = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_rsp_valid"}, {30'd0, rsp_valid}, 0);
      chk({nm, "_busy"}, {31'd0, busy}, 0);
      chk({nm, "_dec_sel"}, {30'd0, dec_sel}, 0);
      chk({nm, "_dec_bits"}, {16'd0, dec_bits}, 0);
      chk({nm, "_rsp_data"}, {24'd0, rsp_data}, 0);
      chk({nm, "_req_ready"}, {30'd0, req_ready}, 0);
      chk({nm, "_cnt0"}, {28'd0, grant_cnt0}, 0);
      chk({nm, "_cnt1"}, {28'd0, grant_cnt1}, 0);
   endtask

   typedef struct {
      logic [1:0] v; logic [1:0] s0; logic [15:0] b0; logic [1:0] s1; logic [15:0] b1; logic [1:0] win;
   } vec_t;
   vec_t tbl[8];

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [1:0] got;
      logic [7:0] held;
      tbl[0] = '{2'b11, 2'b01, 16'h8000, 2'b10, 16'h4000, 2'b01};
      tbl[1] = '{2'b11, 2'b11, 16'h2000, 2'b01, 16'h6000, 2'b10};
      tbl[2] = '{2'b01, 2'b00, 16'h1234, 2'b11, 16'h0000, 2'b01};
      tbl[3] = '{2'b01, 2'b10, 16'h0F00, 2'b01, 16'hFFFF, 2'b01};
      tbl[4] = '{2'b11, 2'b01, 16'h0100, 2'b10, 16'h3000, 2'b10};
      tbl[5] = '{2'b10, 2'b00, 16'h0000, 2'b11, 16'h0A00, 2'b10};
      tbl[6] = '{2'b11, 2'b01, 16'h1800, 2'b01, 16'h0080, 2'b01};
      tbl[7] = '{2'b10, 2'b11, 16'hFFFF, 2'b10, 16'h0010, 2'b10};

      req_valid = 2'b11;
      #2;
      chk_reset_vals("rst");
      do_reset();

      // single request
      req_sel[0] = 2'b01; req_bits[0] = 16'h8000; rsp_ready = 2'b01; req_valid = 2'b01;
      wait_accept("single", got);
      req_valid = 2'b00;
      chk("single_dec_bits", {16'd0, dec_bits}, 32'h8000);
      chk("single_dec_sel", {30'd0, dec_sel}, 1);
      chk("single_busy", {31'd0, busy}, 1);
      chk("single_cnt0", {28'd0, grant_cnt0}, {28'd0, cexp(1)});
      tick(1);
      chk("single_rv_early", {30'd0, rsp_valid}, 0);
      tick(1);
      chk("single_rv", {30'd0, rsp_valid}, 1);
      chk("single_data", {24'd0, rsp_data}, 0);
      wait_idle("single");

      // vector table
      do_reset();
      rsp_ready = 2'b11;
      for (int i = 0; i < 8; i++) begin
         req_sel[0] = tbl[i].s0; req_bits[0] = tbl[i].b0;
         req_sel[1] = tbl[i].s1; req_bits[1] = tbl[i].b1;
         req_valid = tbl[i].v;
         wait_accept("tbl", got);
         req_valid = 2'b00;
         chk($sformatf("tbl%0d_win", i), {30'd0, got}, {30'd0, tbl[i].win});
         chk($sformatf("tbl%0d_bits", i), {16'd0, dec_bits}, {16'd0, tbl[i].win[1] ? tbl[i].b1 : tbl[i].b0});
         wait_idle("tbl");
      end
      chk("tbl_cnt0", {28'd0, grant_cnt0}, {28'd0, cexp(4)});
      chk("tbl_cnt1", {28'd0, grant_cnt1}, {28'd0, cexp(4)});

      // contention: last grant was 1, so order is 0,1,0,1
      req_sel[0] = 2'b01; req_bits[0] = 16'h2800; req_sel[1] = 2'b10; req_bits[1] = 16'h0500;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_accept("cont", got);
         chk($sformatf("cont%0d_order", k), {30'd0, got}, k[0] ? 2 : 1);
         chk_gap = 1;
      end
      req_valid = 2'b00;
      chk_gap = 0;
      wait_idle("cont");

      // backpressure
      rsp_ready = 2'b00;
      req_sel[0] = 2'b11; req_bits[0] = 16'h0300;
      req_valid = 2'b01;
      wait_accept("bp", got);
      req_valid = 2'b11;
      tick(LAT);
      chk("bp_rv", {30'd0, rsp_valid}, 1);
      held = rsp_data;
      rsp_ready = 2'b10;
      for (int k = 0; k < 5; k++) begin
         tick(1);
         chk("bp_hold_rv", {30'd0, rsp_valid}, 1);
         chk("bp_hold_data", {24'd0, rsp_data}, {24'd0, held});
         chk("bp_hold_ready", {30'd0, req_ready}, 0);
      end
      req_valid = 2'b00;
      rsp_ready = 2'b01;
      tick(1);
      chk("bp_done_rv", {30'd0, rsp_valid}, 0);
      chk("bp_done_busy", {31'd0, busy}, 0);
      wait_idle("bp");

      // flush one cycle into WAIT, then the other requester wins
      rsp_ready = 2'b11;
      req_sel[1] = 2'b01; req_bits[1] = 16'h0C00;
      req_valid = 2'b01;
      wait_accept("fl", got);
      flush = 1'b1;
      req_valid = 2'b11;
      tick(1);
      chk("fl_rv", {30'd0, rsp_valid}, 0);
      chk("fl_busy", {31'd0, busy}, 0);
      chk("fl_ready_blocked", {30'd0, req_ready}, 0);
      tick(1);
      chk("fl_idle_blocked", {30'd0, req_ready}, 0);
      flush = 1'b0;
      wait_accept("fl_next", got);
      req_valid = 2'b00;
      chk("fl_next_win", {30'd0, got}, 2);
      wait_idle("fl");

      // async reset mid-WAIT
      req_valid = 2'b01;
      wait_accept("ar", got);
      req_valid = 2'b11;
      #3 reset_n = 1'b0;
      #1 chk_reset_vals("ar");
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      wait_accept("ar_first", got);
      req_valid = 2'b00;
      chk("ar_first_win", {30'd0, got}, 1);
      wait_idle("ar");

      // 17 grants to requester 1
      do_reset();
      req_valid = 2'b10;
      for (int k = 0; k < 17; k++) wait_accept("wrap", got);
      req_valid = 2'b00;
      wait_idle("wrap");
      chk("wrap_cnt1", {28'd0, grant_cnt1}, {28'd0, cexp(17)});
      chk("wrap_cnt0", {28'd0, grant_cnt0}, 0);
      chk("sb_left", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/egd_arbiter.md
# egd_arbiter

Round-robin arbiter and sequencer that shares one Exp-Golomb decoder (`egd_top`) between two requesters, for example a slice-header parser and a macroblock parser. It accepts one decode request at a time, holding the 16-bit bitstream window and the 2-bit Exp-Golomb select stable on the decoder for a fixed number of cycles. It then captures the decoded byte and returns it to the requester that issued it. It sits between the parsing front-ends and `egd_top`, inside the user-project wrapper.

## Interface
Parameters:
- `DEC_LAT`, default 2: number of cycles the decoder inputs are held stable before the output is sampled; legal range 1..15.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort of any in-flight request.
- `req_valid`  in  2  per-requester request valid.
- `req_sel`  in  2x2  per-requester Exp-Golomb select (`req_sel0`, `req_sel1`).
- `req_bits`  in  2x16  per-requester bitstream window (`req_bits0`, `req_bits1`).
- `req_ready`  out  2  per-requester accept; one-hot or zero.
- `rsp_valid`  out  2  per-requester response valid; one-hot or zero.
- `rsp_data`  out  8  decoded value; shared by both requesters.
- `rsp_ready`  in  2  per-requester response accept.
- `dec_sel`  out  2  to `egd_top` `exp_golomb_sel`.
- `dec_bits`  out  16  to `egd_top` `BitStream_buffer_input`.
- `dec_out`  in  8  from `egd_top` `exp_golomb_decoding_output`.
- `busy`  out  1  high in WAIT or RESP.
- `grant_cnt0`, `grant_cnt1`  out  `CNT_W`  accepted-request counters per requester.

## Operation
States: IDLE, WAIT, RESP.

**IDLE**
- `req_ready` is driven combinationally to the winner among the requesters with `req_valid` high.
- Arbitration is round-robin: when both are valid, the requester that is not `last_grant` wins.
- A handshake is `req_valid[i] && req_ready[i]` at a clock edge. On a handshake:
  - `dec_sel <= req_sel_i`, `dec_bits <= req_bits_i`;
  - `gnt <= i`, `last_grant <= i`;
  - `cnt <= DEC_LAT`;
  - go to WAIT.

**WAIT**
- `req_ready` is 0.
- `cnt` decrements every edge.
- At the edge where `cnt == 1`: `rsp_data <= dec_out`, `rsp_valid[gnt] <= 1`, go to RESP.

**RESP**
- `rsp_valid[gnt]` is held until `rsp_ready[gnt]` is high at an edge.
- On that edge `rsp_valid` clears and the state goes to IDLE.
- `rsp_ready` of the other requester, or any `rsp_ready` outside RESP, is ignored.

**Held values**
- `dec_sel` and `dec_bits` hold their last issued value in all states. They change only on a handshake.
- `rsp_data` holds until the next capture.

**Flush**
- `flush` in WAIT or RESP: go to IDLE, clear `rsp_valid`. No response is delivered; `last_grant` keeps its updated value.
- `flush` in IDLE blocks the handshake: `req_ready` is 0 while `flush` is high.

**Reset values**
- `dec_sel`, `dec_bits`, `rsp_data`, `rsp_valid`, `gnt` and the counters are 0; `busy` is 0.
- `cnt` resets to 0, `last_grant` to 1 (so requester 0 has first priority), and the state to IDLE.
- `req_ready` is 0 while in reset.

**Reset during operation**
- An asserted reset drops any in-flight request immediately, regardless of state.

## Timing
- Accept edge E0: `dec_sel` and `dec_bits` are valid after E0 and stable for exactly `DEC_LAT` cycles.
- `rsp_valid` rises after edge E`DEC_LAT`.
- Minimum request-to-request interval: `DEC_LAT + 2` cycles when `rsp_ready` is held high. This comprises `DEC_LAT` cycles in WAIT, one cycle in RESP, and one cycle in IDLE.
- No back-to-back acceptance: IDLE always lasts at least one cycle.
- `req_ready` is combinational from `req_valid`, `flush` and state. All other outputs are registered.
- `busy` is registered, equal to `state != IDLE`.

## Configuration
Macro: `EGD_PERF_CNT_EN`.
- Defined: `grant_cnt0` and `grant_cnt1` increment by 1 on each handshake of their requester and wrap modulo 2^`CNT_W`. `flush` does not clear them; only `reset_n` does.
- Undefined: no counter registers are built and both ports are tied to 0. The ports remain so the wrapper connections do not change.

## Test plan
- **Single request.** Reset, `DEC_LAT=2`, requester 0 issues `sel=2'b01`, `bits=16'h8000`, decoder model returns `8'h00`.
  - `dec_bits=16'h8000` from the cycle after the accept edge.
  - `rsp_valid=2'b01` and `rsp_data=8'h00` two edges after accept.
  - `grant_cnt0=1` when `EGD_PERF_CNT_EN` is defined.
- **Contention.** Both requesters hold `req_valid` with `rsp_ready=2'b11`.
  - Grant order is 0,1,0,1.
  - Handshakes occur exactly `DEC_LAT+2` cycles apart.
  - `req_ready` is never `2'b11`.
- **Backpressure.** Hold `rsp_ready[gnt]=0` for 5 cycles in RESP.
  - `rsp_valid` and `rsp_data` stay stable.
  - `req_ready` stays 0.
  - The response completes on the first edge where `rsp_ready=1`.
- **Flush.** Assert `flush` one cycle into WAIT.
  - Next cycle: state IDLE, `rsp_valid=0`, `busy=0`.
  - A new request from the other requester is granted next.
- **Async reset.** Drop `reset_n` mid-WAIT, asynchronously to `clk`.
  - All outputs return to their reset values immediately.
  - After release, the first simultaneous request is granted to requester 0.
- **Counter wrap.** With `CNT_W=4` and the macro defined, issue 17 requests from requester 1 → `grant_cnt1=1`.
